jtcps1_pal_dma: RTL and testbench



---
 rtl/jtcps1_pkg.sv | 25 ++
 rtl/jtcps1_pal_dma.sv | 151 +++++++++++++++
 tb/tb_jtcps1_pal_dma.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcps1_pkg.sv
// Shared constants and types for the CPS1 palette copy engine.
package jtcps1_pkg;

  localparam int PAGES   = 6;             // palette pages copied per request
  localparam int PAGE_AW = 9;             // words per page = 2**PAGE_AW
  localparam int PAL_AW  = 12;            // palette RAM address: {page, index}
  localparam int VRAM_AW = 17;            // VRAM word address width
  localparam int PAGE_W  = PAL_AW - PAGE_AW;  // page counter width (0..PAGES)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_WR,
    ST_FIN
  } pal_dma_state_t;

  // pal_base counts 256-byte units, i.e. 128 VRAM words.
  function automatic logic [VRAM_AW-1:0] base_to_src(input logic [15:0] base);
    logic [16:0] words;
    words = {base[9:0], 7'd0};
    return words[VRAM_AW-1:0];
  endfunction

endpackage

// File: rtl/jtcps1_pal_dma.sv
// Palette copy engine: walks the enabled palette pages, reads each word from
// VRAM through the shared SDRAM port and writes it into the palette RAM.
module jtcps1_pal_dma
  import jtcps1_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               pal_copy,
  input  logic [15:0]        pal_base,
  input  logic [PAGES-1:0]   pal_page_en,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_cs,
  input  logic               vram_ok,
  input  logic [15:0]        vram_data,
  output logic [PAL_AW-1:0]  pal_addr,
  output logic [15:0]        pal_data,
  output logic               pal_we,
  output logic               busy,
  output logic               done
);

  localparam logic [PAGE_W-1:0]  LAST_PAGE   = PAGE_W'(PAGES);
  localparam logic [PAGE_AW-1:0] LAST_IDX    = '1;
  localparam logic [VRAM_AW-1:0] PAGE_STRIDE = VRAM_AW'(1 << PAGE_AW);

  pal_dma_state_t state_reg, state_next;

  logic [PAGE_W-1:0]      page_reg;
  logic [PAGE_AW-1:0]     idx_reg;
  logic [VRAM_AW-1:0]     src_reg;
  logic [PAGES-1:0]       en_reg;
  logic                   pending_reg;
  logic                   done_reg;
  logic [15:0]            pal_data_reg;

  // Mask padded to the full page-counter range so page==PAGES reads as off
  logic [(1<<PAGE_W)-1:0] en_ext;
  logic                   page_end;
  logic                   page_on;
  logic                   last_word;
  logic                   restart;

  // Decode helpers for the current page/word position
  always_comb begin
    en_ext             = '0;
    en_ext[PAGES-1:0]  = en_reg;
    page_end           = (page_reg == LAST_PAGE);
    page_on            = en_ext[page_reg];
    last_word          = (idx_reg == LAST_IDX);
    // A pulse arriving during FIN counts as a pending request
    restart            = pending_reg | pal_copy;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pal_copy) state_next = ST_SCAN;
      ST_SCAN: begin
        if (page_end)     state_next = ST_FIN;
        else if (page_on) state_next = ST_REQ;
        else              state_next = ST_SCAN;
      end
      ST_REQ:  if (vram_ok) state_next = ST_WR;
      ST_WR:   state_next = last_word ? ST_SCAN : ST_REQ;
      ST_FIN:  state_next = restart ? ST_SCAN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the position registers
  always_comb begin
    vram_cs   = (state_reg == ST_REQ);
    vram_addr = src_reg + VRAM_AW'(idx_reg);
    pal_we    = (state_reg == ST_WR);
    pal_addr  = {page_reg, idx_reg};
    pal_data  = pal_data_reg;
    busy      = (state_reg != ST_IDLE);
    done      = done_reg;
  end

  // Copy position, latched request parameters, read data and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      page_reg     <= '0;
      idx_reg      <= '0;
      src_reg      <= '0;
      en_reg       <= '0;
      pal_data_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_FIN);
      case (state_reg)
        ST_IDLE: begin
          if (pal_copy) begin
            src_reg  <= base_to_src(pal_base);
            en_reg   <= pal_page_en;
            page_reg <= '0;
            idx_reg  <= '0;
          end
        end
        ST_SCAN: begin
          // Disabled pages are skipped without consuming source words
          if (!page_end && !page_on) page_reg <= page_reg + PAGE_W'(1);
        end
        ST_REQ: begin
          if (vram_ok) pal_data_reg <= vram_data;
        end
        ST_WR: begin
          if (last_word) begin
            idx_reg  <= '0;
            src_reg  <= src_reg + PAGE_STRIDE;
            page_reg <= page_reg + PAGE_W'(1);
          end else begin
            idx_reg  <= idx_reg + PAGE_AW'(1);
          end
        end
        ST_FIN: begin
          // Pending copies sample the inputs now, not when the pulse came
          if (restart) begin
            src_reg  <= base_to_src(pal_base);
            en_reg   <= pal_page_en;
            page_reg <= '0;
            idx_reg  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending request flag: set by pulses while busy, consumed by FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: pending_reg <= 1'b0;
        ST_FIN:  pending_reg <= 1'b0;
        default: if (pal_copy) pending_reg <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Scoreboard bench for the palette copy engine: a VRAM model answers reads,
// a reference model predicts every VRAM address and palette write.
module tb_jtcps1_pal_dma;

  logic        clk;
  logic        rst;
  logic        pal_copy;
  logic [15:0] pal_base;
  logic [5:0]  pal_page_en;
  logic [16:0] vram_addr;
  logic        vram_cs;
  logic        vram_ok;
  logic [15:0] vram_data;
  logic [11:0] pal_addr;
  logic [15:0] pal_data;
  logic        pal_we;
  logic        busy;
  logic        done;

  jtcps1_pal_dma dut (
    .clk         (clk),
    .rst         (rst),
    .pal_copy    (pal_copy),
    .pal_base    (pal_base),
    .pal_page_en (pal_page_en),
    .vram_addr   (vram_addr),
    .vram_cs     (vram_cs),
    .vram_ok     (vram_ok),
    .vram_data   (vram_data),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .pal_we      (pal_we),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:131071];
  logic [16:0] exp_addr[$];
  logic [27:0] exp_wr[$];

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt, wr_cnt, busy_cyc, first_cs_edge, done_edge, copy_edge;
  int ack_fixed = 2;
  bit resp_en   = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: enabled pages are read back to back from the base,
  // each written to its own page slot in palette RAM.
  task automatic push_copy(input logic [15:0] base, input logic [5:0] mask);
    int k;
    int a;
    k = 0;
    for (int p = 0; p < 6; p++) begin
      if (mask[p]) begin
        for (int i = 0; i < 512; i++) begin
          a = (int'(base[9:0]) * 128 + k * 512 + i) % 131072;
          exp_addr.push_back(17'(a));
          exp_wr.push_back({3'(p), 9'(i), mem[a]});
        end
        k++;
      end
    end
  endtask

  task automatic begin_test();
    done_cnt      = 0;
    wr_cnt        = 0;
    busy_cyc      = 0;
    first_cs_edge = -1;
    done_edge     = -1;
  endtask

  task automatic pulse_copy(input logic [15:0] base, input logic [5:0] mask);
    @(negedge clk);
    pal_base    = base;
    pal_page_en = mask;
    pal_copy    = 1'b1;
    @(negedge clk);
    pal_copy  = 1'b0;
    copy_edge = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic end_test(input string nm, input int words);
    chk("wr_count", 32'(wr_cnt), 32'(words));
    chk("addr_queue_left", 32'(exp_addr.size()), 32'd0);
    chk("wr_queue_left", 32'(exp_wr.size()), 32'd0);
    $display("copy %s: %0d writes, %0d done pulses, %0d busy cycles", nm, wr_cnt, done_cnt, busy_cyc);
  endtask

  // VRAM responder: acks after ack_fixed extra cycles (random 0..2 if negative)
  initial begin
    int lat;
    lat       = -1;
    vram_ok   = 1'b0;
    vram_data = 16'h0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        vram_ok = 1'b0;
        if (vram_cs && !rst) begin
          if (lat < 0) lat = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(2, 0));
          if (lat == 0) begin
            vram_ok   = 1'b1;
            vram_data = mem[vram_addr];
            lat       = -1;
          end else begin
            lat--;
          end
        end else begin
          lat = -1;
        end
      end else begin
        lat = -1;
      end
    end
  end

  // Monitor: pops the scoreboard on every read request and palette write
  initial begin
    logic        cs_prev;
    logic [16:0] cs_addr;
    logic [16:0] ea;
    logic [27:0] ew;
    cs_prev = 1'b0;
    cs_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cs_prev = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (done) begin
          done_cnt++;
          done_edge = cyc;
        end
        if (vram_cs && !cs_prev) begin
          if (first_cs_edge < 0) first_cs_edge = cyc;
          cs_addr = vram_addr;
          if (exp_addr.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_read: got vram_addr 0x%0h, required no request", vram_addr);
          end else begin
            ea = exp_addr.pop_front();
            chk("vram_addr", 32'(vram_addr), 32'(ea));
          end
        end else if (vram_cs && vram_addr !== cs_addr) begin
          n_checks++;
          n_err++;
          $display("FAIL vram_addr_stable: got 0x%0h required 0x%0h", vram_addr, cs_addr);
        end
        if (pal_we) begin
          wr_cnt++;
          chk("we_cs_overlap", 32'(vram_cs), 32'd0);
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", pal_addr, pal_data);
          end else begin
            ew = exp_wr.pop_front();
            chk("pal_write", 32'({pal_addr, pal_data}), 32'(ew));
          end
        end
        cs_prev = vram_cs;
      end
    end
  end

  initial begin
    logic [15:0] b;
    logic [5:0]  m;
    int          words;
    for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
    rst         = 1'b1;
    pal_copy    = 1'b0;
    pal_base    = 16'h0;
    pal_page_en = 6'h0;
    begin_test();
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_vram_cs", 32'(vram_cs), 32'd0);
    chk("rst_pal_addr", 32'(pal_addr), 32'd0);
    chk("rst_pal_data", 32'(pal_data), 32'd0);
    chk("rst_pal_we", 32'(pal_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single page, REQ held three cycles per word
    begin_test();
    ack_fixed = 2;
    push_copy(16'h0040, 6'h01);
    pulse_copy(16'h0040, 6'h01);
    wait_done(1, 20000);
    chk("first_cs_latency", 32'(first_cs_edge - copy_edge), 32'd1);
    // One SCAN per page index 0..PAGES, one FIN, (3 REQ + 1 WR) per word
    chk("busy_cycles", 32'(busy_cyc), 32'(7 + 1 + 512 * 4));
    end_test("single", 512);

    // Sparse mask: pages 0, 3, 5 from consecutive source pages
    begin_test();
    ack_fixed = -1;
    push_copy(16'h0000, 6'b101001);
    pulse_copy(16'h0000, 6'b101001);
    wait_done(1, 20000);
    end_test("sparse", 1536);

    // Empty mask: only scanning, FIN seven edges after the start edge
    begin_test();
    pulse_copy(16'h1234, 6'h00);
    wait_done(1, 200);
    chk("empty_done_latency", 32'(done_edge - copy_edge), 32'd8);
    chk("empty_no_cs", 32'(first_cs_edge), 32'hFFFF_FFFF);
    end_test("empty", 0);

    // Retrigger mid copy: pulses collapse, second copy uses the new base
    begin_test();
    push_copy(16'h0040, 6'h01);
    pulse_copy(16'h0040, 6'h01);
    for (int n = 0; n < 5000 && wr_cnt < 100; n++) @(negedge clk);
    chk("retrig_reach_word100", 32'(wr_cnt >= 100), 32'd1);
    push_copy(16'h0080, 6'h01);
    pulse_copy(16'h0080, 6'h01);
    for (int n = 0; n < 5000 && wr_cnt < 200; n++) @(negedge clk);
    pulse_copy(16'h0080, 6'h01);
    wait_done(2, 20000);
    end_test("retrigger", 1024);

    // Wrap of the VRAM address inside page 0
    begin_test();
    push_copy(16'h03FF, 6'h03);
    pulse_copy(16'h03FF, 6'h03);
    wait_done(1, 20000);
    end_test("wrap", 1024);

    // Reset during REQ with the ack outstanding, then a late ack
    begin_test();
    ack_fixed = 1000;
    push_copy(16'h0155, 6'h3f);
    pulse_copy(16'h0155, 6'h3f);
    for (int n = 0; n < 50 && first_cs_edge < 0; n++) @(negedge clk);
    chk("rst_test_cs_seen", 32'(first_cs_edge >= 0), 32'd1);
    repeat (2) @(negedge clk);
    resp_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_addr.delete();
    exp_wr.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_vram_cs", 32'(vram_cs), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    vram_ok   = 1'b1;
    vram_data = 16'hBEEF;
    @(negedge clk);
    vram_ok = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("late_ok_vram_cs", 32'(vram_cs), 32'd0);
      chk("late_ok_pal_we", 32'(pal_we), 32'd0);
      chk("late_ok_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    resp_en   = 1'b1;
    ack_fixed = -1;
    end_test("reset_mid", 0);

    // Randomized copies
    for (int r = 0; r < 3; r++) begin
      begin_test();
      b = 16'($urandom);
      m = 6'($urandom_range(63, 1));
      words = 512 * $countones(m);
      push_copy(b, m);
      pulse_copy(b, m);
      wait_done(1, 20000);
      $display("random copy base 0x%04h mask 0x%02h", b, m);
      end_test("random", words);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
